// File: rtl/pc_fetch_queue.sv
// Instruction-fetch stage: PC register, next-PC select, imem address and a small fetch FIFO to decode.
// Latency 1 cycle imem->head when empty; decode stalls hold the PC, redirects flush the buffer.
module pc_fetch_queue #(
  parameter int                  DATA_WIDTH      = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC      = '0,
  parameter int                  FIFO_DEPTH      = 4,
  parameter int                  IMEM_ADDR_WIDTH = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          redirect_valid,
  input  logic [DATA_WIDTH-1:0]         redirect_target,
  output logic [IMEM_ADDR_WIDTH-1:0]    imem_addr,
  input  logic [DATA_WIDTH-1:0]         imem_rdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_instr,
  output logic [DATA_WIDTH-1:0]         out_pc,
  output logic [DATA_WIDTH-1:0]         out_pcplus4,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] r_pc;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  logic [DATA_WIDTH-1:0] r_instr_mem   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_pc_mem      [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_pcplus4_mem [FIFO_DEPTH];

  logic                  w_pop;
  logic                  w_push;
  logic [DATA_WIDTH-1:0] w_pc_plus4;

  assign w_pc_plus4 = r_pc + DATA_WIDTH'(4);
  assign out_valid  = (r_count != '0);
  assign w_pop      = out_valid & out_ready;
  // A full buffer can still accept a fetch when the head leaves in the same cycle.
  assign w_push     = !redirect_valid & ((r_count < DEPTH_C) | w_pop);

  assign imem_addr   = r_pc[IMEM_ADDR_WIDTH-1:0];
  assign out_instr   = r_instr_mem[r_rd_ptr];
  assign out_pc      = r_pc_mem[r_rd_ptr];
  assign out_pcplus4 = r_pcplus4_mem[r_rd_ptr];
  assign fifo_count  = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      r_pc     <= {redirect_target[DATA_WIDTH-1:2], 2'b00};
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_pc     <= w_pc_plus4;
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Payload storage needs no reset; out_valid qualifies it.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_instr_mem[r_wr_ptr]   <= imem_rdata;
      r_pc_mem[r_wr_ptr]      <= r_pc;
      r_pcplus4_mem[r_wr_ptr] <= w_pc_plus4;
    end
  end

endmodule

// File: tb/tb_pc_fetch_queue.sv
// Bench for pc_fetch_queue: directed scenarios plus randomized traffic against a queue-based model.
module tb_pc_fetch_queue;

  localparam logic [31:0] RPC0 = 32'h0000_0100;
  localparam logic [31:0] RPC1 = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst, redirect_valid, out_ready;
  logic [31:0] redirect_target;
  logic [11:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_instr, out_pc, out_pcplus4;
  logic [2:0]  fifo_count;

  logic        rst1, rv1, ready1;
  logic [31:0] tgt1;
  logic [11:0] imem_addr1;
  logic [31:0] imem_rdata1;
  logic        out_valid1;
  logic [31:0] out_instr1, out_pc1, out_pcplus41;
  logic [2:0]  fifo_count1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_pc;
  logic [31:0] m_q[$];

  always #5 clk = ~clk;

  assign imem_rdata  = {20'h0, imem_addr}  ^ 32'hA5A5_0000;
  assign imem_rdata1 = {20'h0, imem_addr1} ^ 32'hA5A5_0000;

  pc_fetch_queue #(.DATA_WIDTH(32), .RESET_PC(RPC0), .FIFO_DEPTH(4), .IMEM_ADDR_WIDTH(12)) dut0 (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_pcplus4(out_pcplus4), .fifo_count(fifo_count));

  pc_fetch_queue #(.DATA_WIDTH(32), .RESET_PC(RPC1), .FIFO_DEPTH(4), .IMEM_ADDR_WIDTH(12)) dut1 (
    .clk(clk), .rst(rst1), .redirect_valid(rv1), .redirect_target(tgt1),
    .imem_addr(imem_addr1), .imem_rdata(imem_rdata1), .out_valid(out_valid1), .out_ready(ready1),
    .out_instr(out_instr1), .out_pc(out_pc1), .out_pcplus4(out_pcplus41), .fifo_count(fifo_count1));

  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    return {20'h0, pc[11:0]} ^ 32'hA5A5_0000;
  endfunction

  // Reference model: a PC and a queue of fetched PCs, updated from the inputs of the coming edge.
  task automatic model_update(input logic r, input logic rv, input logic [31:0] tgt, input logic rdy);
    logic [31:0] dummy;
    bit pop, push;
    if (r) begin
      m_pc = RPC0;
      m_q.delete();
    end else if (rv) begin
      m_pc = tgt & 32'hFFFF_FFFC;
      m_q.delete();
    end else begin
      pop  = (m_q.size() != 0) && rdy;
      push = (m_q.size() < 4) || pop;
      if (pop) dummy = m_q.pop_front();
      if (push) begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic step(input logic r, input logic rv, input logic [31:0] tgt, input logic rdy);
    rst = r; redirect_valid = rv; redirect_target = tgt; out_ready = rdy;
    model_update(r, rv, tgt, rdy);
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0400, 1'b1);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    n_checks++; if (imem_addr !== 12'h100) begin n_fail++; $display("FAIL reset_addr got %h want 100", imem_addr); end
  endtask

  task automatic test_stream;
    logic [31:0] want;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      want = RPC0 + 32'(4 * i);
      n_checks++; if (out_valid !== 1'b1 || out_pc !== want) begin
        n_fail++; $display("FAIL stream_pc[%0d] got v=%b %h want v=1 %h", i, out_valid, out_pc, want); end
      n_checks++; if (out_instr !== exp_instr(want)) begin
        n_fail++; $display("FAIL stream_instr[%0d] got %h want %h", i, out_instr, exp_instr(want)); end
      step(1'b0, 1'b0, 32'h0, 1'b1);
    end
  endtask

  task automatic test_stall;
    logic [31:0] want;
    step(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL stall_count got %0d want 4", fifo_count); end
    n_checks++; if (imem_addr !== 12'h110) begin n_fail++; $display("FAIL stall_addr got %h want 110", imem_addr); end
    for (int i = 0; i < 5; i++) begin
      want = RPC0 + 32'(4 * i);
      n_checks++; if (out_valid !== 1'b1 || out_pc !== want) begin
        n_fail++; $display("FAIL drain_pc[%0d] got v=%b %h want v=1 %h", i, out_valid, out_pc, want); end
      step(1'b0, 1'b0, 32'h0, 1'b1);
    end
  endtask

  task automatic test_redirect;
    step(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++; if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL redir_pre_count got %0d want 3", fifo_count); end
    step(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    n_checks++; if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
      n_fail++; $display("FAIL redir_flush got v=%b c=%0d want v=0 c=0", out_valid, fifo_count); end
    step(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_pcplus4 !== 32'h204) begin
      n_fail++; $display("FAIL redir_target got v=%b pc=%h p4=%h want 1 200 204", out_valid, out_pc, out_pcplus4); end
    step(1'b0, 1'b1, 32'h0000_0203, 1'b0);
    n_checks++; if (imem_addr !== 12'h200) begin n_fail++; $display("FAIL redir_align_addr got %h want 200", imem_addr); end
    step(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++; if (out_pc !== 32'h200) begin n_fail++; $display("FAIL redir_align_pc got %h want 200", out_pc); end
  endtask

  task automatic test_rst_over_redirect;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL prio_full got %0d want 4", fifo_count); end
    step(1'b1, 1'b1, 32'h0000_0300, 1'b1);
    n_checks++; if (fifo_count !== 3'd0 || out_valid !== 1'b0 || imem_addr !== 12'h100) begin
      n_fail++; $display("FAIL prio_reset got c=%0d v=%b a=%h want 0 0 100", fifo_count, out_valid, imem_addr); end
  endtask

  task automatic test_wrap;
    rv1 = 1'b0; tgt1 = 32'h0; ready1 = 1'b0; rst1 = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (imem_addr1 !== 12'hFFC) begin n_fail++; $display("FAIL wrap_addr got %h want ffc", imem_addr1); end
    rst1 = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (out_pc1 !== RPC1 || out_pcplus41 !== 32'h0) begin
      n_fail++; $display("FAIL wrap_first got pc=%h p4=%h want fffffffc 0", out_pc1, out_pcplus41); end
    ready1 = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (out_valid1 !== 1'b1 || out_pc1 !== 32'h0 || out_instr1 !== 32'hA5A5_0000) begin
      n_fail++; $display("FAIL wrap_second got v=%b pc=%h i=%h want 1 0 a5a50000", out_valid1, out_pc1, out_instr1); end
    ready1 = 1'b0;
  endtask

  task automatic test_random;
    logic r, rv, rdy;
    logic [31:0] tgt;
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 49) == 0);
      rv  = ($urandom_range(0, 11) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      tgt = $urandom;
      step(r, rv, tgt, rdy);
      n_checks++; if (out_valid !== (m_q.size() != 0) || fifo_count !== 3'(m_q.size())) begin
        n_fail++; $display("FAIL rand_occ[%0d] got v=%b c=%0d want c=%0d", i, out_valid, fifo_count, m_q.size()); end
      n_checks++; if (imem_addr !== m_pc[11:0]) begin
        n_fail++; $display("FAIL rand_addr[%0d] got %h want %h", i, imem_addr, m_pc[11:0]); end
      if (m_q.size() != 0) begin
        n_checks++;
        if (out_pc !== m_q[0] || out_pcplus4 !== m_q[0] + 32'd4 || out_instr !== exp_instr(m_q[0])) begin
          n_fail++; $display("FAIL rand_head[%0d] got pc=%h p4=%h i=%h want pc=%h", i, out_pc, out_pcplus4, out_instr, m_q[0]); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_target = '0; out_ready = 1'b0;
    rst1 = 1'b1; rv1 = 1'b0; tgt1 = '0; ready1 = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_rst_over_redirect();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
